adc_conv_responder: RTL and testbench
=====================================

# adc_conv_responder

Synthesizable emulator of the ADC side of the start/EOC/OE conversion handshake. It latches a digital stand-in for the analog input on each start pulse, drops EOC for a programmable conversion time, then raises EOC with the result held in an output latch that OE gates onto the data bus. It sits opposite the sampling controller in simulation benches and FPGA loopback builds, so the controller can be exercised without a physical converter.

## Interface
- DATA_W, 8: result width in bits.
- EOC_DELAY, 4: clk cycles from start rising edge until EOC falls; must be ≥1.
- CONV_CYCLES, 64: clk cycles EOC stays low; must be ≥1.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- sample_in  input  DATA_W  digital stand-in for the analog input; captured on start edge.
- start  input  1  conversion request; the rising edge is the event.
- oe  input  1  output enable for the result latch.
- eoc  output  1  end of conversion; high when idle or done, low while converting.
- dout  output  DATA_W  result bus; zero when oe is low.
- busy  output  1  high in DELAY or CONVERT.

## Operation
- Edge detect: start_d is start delayed by 1 cycle. start_rise = start & ~start_d. start_d resets to 0.
- States: IDLE, DELAY, CONVERT, DONE.
- Transitions:
  - In any state, start_rise goes to DELAY, loads cnt = EOC_DELAY-1 and captures sample_q <= sample_in. A start during DELAY/CONVERT/DONE aborts the current conversion and restarts it. result_q is not modified on abort.
  - DELAY: decrement cnt. At 0 go to CONVERT and load cnt = CONV_CYCLES-1.
  - CONVERT: decrement cnt. At 0 go to DONE and write result_q <= conv(sample_q).
  - DONE: hold until the next start_rise. There is no return to IDLE. IDLE exists only after reset.
- eoc = 0 in CONVERT and 1 in all other states. It is registered together with the state.
- busy = 1 in DELAY or CONVERT.
- dout is registered: dout <= oe ? result_q : 0. If oe is high during a conversion, dout carries the previous result_q.
- cnt width: $clog2(max(EOC_DELAY, CONV_CYCLES)+1).
- conv(x) = x unless dither is enabled (see Configuration).
- Reset values: state = IDLE, eoc = 1, busy = 0, dout = 0, result_q = 0, sample_q = 0, cnt = 0, start_d = 0.
- Reset has priority over start_rise in the same cycle.

## Timing
- Let T be the cycle in which start is first sampled high.
- Cycles T+1 .. T+EOC_DELAY: busy = 1, eoc = 1.
- Cycles T+EOC_DELAY+1 .. T+EOC_DELAY+CONV_CYCLES: eoc = 0.
- From cycle T+EOC_DELAY+CONV_CYCLES+1: eoc = 1, busy = 0, new result_q valid.
- oe to dout latency: 1 cycle. Deasserting oe gives dout = 0 on the next cycle.
- Holding start high across cycles does not retrigger. It must return low for at least 1 cycle before the next edge.
- A start_rise in the same cycle as the CONVERT→DONE transition takes priority: the restart wins and result_q is not updated.

## Configuration
- ADC_RESP_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on rst) advances every cycle.
  - At the result write, conv(x) applies a dither based on lfsr[1:0]:
    - 2'b01: x+1, saturating at all-ones.
    - 2'b10: x-1, saturating at 0.
    - otherwise: x unchanged.
- ADC_RESP_DITHER_EN undefined: no LFSR logic is generated, and conv(x) = x exactly.

## Structure
- Package adc_pkg holds:
  - the state enum (IDLE, DELAY, CONVERT, DONE);
  - the LFSR seed and tap constants.
- Sub-module adc_lfsr16 (clk, rst, enable, q[15:0]) is instantiated only under ADC_RESP_DITHER_EN.
- The state machine, counter and latches stay in adc_conv_responder.

## Test plan
All scenarios use EOC_DELAY=4, CONV_CYCLES=16, DATA_W=8, and dither off unless stated.
- Reset: rst held high for 3 cycles → eoc=1, busy=0, dout=0; oe=1 after reset → dout=0.
- Basic conversion:
  - sample_in=8'h5A with a 1-cycle start pulse at T → eoc low exactly T+5..T+20, high at T+21.
  - oe raised at T+22 → dout=8'h5A at T+23.
  - oe dropped → dout=0 one cycle later.
- Restart:
  - Second start edge at T+10 with sample_in=8'h33 → eoc low T+15..T+30.
  - No result written at T+21.
  - Final result 8'h33.
- Stale read: previous result 8'hA5, new conversion of 8'h11, oe high throughout → dout=8'hA5 until the EOC rise, then 8'h11 one cycle later.
- Held start / reset mid-conversion:
  - start held high for 40 cycles → exactly one conversion.
  - rst at T+12 → eoc=1 and busy=0 next cycle; result_q=0.
- Dither (ADC_RESP_DITHER_EN defined): sample_in=8'hFF or 8'h00 over 200 conversions → results stay within 8'hFE..8'hFF and 8'h00..8'h01 respectively; no wrap-around.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion-handshake responder.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CONVERT,
        DONE
    } adc_state_e;

    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1, taps as a bit mask
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/adc_lfsr16.sv
// 16-bit Fibonacci LFSR used as the dither source; advances whenever enable is high.
module adc_lfsr16
    import adc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (enable) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/adc_conv_responder.sv
// ADC-side emulator of the start/EOC/OE handshake with programmable EOC delay and conversion time.
// Optional +/-1 saturating result dither is enabled by defining ADC_RESP_DITHER_EN.
module adc_conv_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int EOC_DELAY   = 4,
    parameter int CONV_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              start,
    input  logic              oe,
    output logic              eoc,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);

    localparam int CNT_MAX = (EOC_DELAY > CONV_CYCLES) ? EOC_DELAY : CONV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(EOC_DELAY - 1);
    localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(CONV_CYCLES - 1);

    adc_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              start_d;
    logic              start_rise;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] conv_value;

    assign start_rise = start & ~start_d;

`ifdef ADC_RESP_DITHER_EN
    logic [15:0] lfsr_q;

    adc_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (1'b1),
        .q      (lfsr_q)
    );

    // NOTE: conv_value gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        conv_value = sample_q;
        case (lfsr_q[1:0])
            2'b01:   if (!(&sample_q)) conv_value = sample_q + DATA_W'(1);
            2'b10:   if (|sample_q)    conv_value = sample_q - DATA_W'(1);
            default: conv_value = sample_q;
        endcase
    end
`else
    assign conv_value = sample_q;
`endif

    // NOTE: all state here uses <= so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            start_d  <= 1'b0;
            sample_q <= '0;
            result_q <= '0;
            eoc      <= 1'b1;
            busy     <= 1'b0;
            dout     <= '0;
        end else begin
            start_d <= start;
            dout    <= oe ? result_q : '0;

            // A fresh start edge restarts from any state and beats the CONVERT->DONE write.
            if (start_rise) begin
                state    <= DELAY;
                cnt      <= DELAY_LOAD;
                sample_q <= sample_in;
                eoc      <= 1'b1;
                busy     <= 1'b1;
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt == '0) begin
                            state <= CONVERT;
                            cnt   <= CONV_LOAD;
                            eoc   <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    CONVERT: begin
                        if (cnt == '0) begin
                            state    <= DONE;
                            result_q <= conv_value;
                            eoc      <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_responder.sv
// Self-checking bench for adc_conv_responder: directed handshake scenarios plus randomized
// conversions, checked every cycle against a timestamp-based reference model.
module tb_adc_conv_responder;

    localparam int DW = 8;
    localparam int ED = 4;
    localparam int CC = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          oe;
    logic [DW-1:0] sample_in;
    logic          eoc;
    logic          busy;
    logic [DW-1:0] dout;

    adc_conv_responder #(
        .DATA_W      (DW),
        .EOC_DELAY   (ED),
        .CONV_CYCLES (CC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sample_in),
        .start     (start),
        .oe        (oe),
        .eoc       (eoc),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: conversion timing derived from the edge index of the last start rise.
    int            cyc = 0;
    int            last_rise = 0;
    bit            active = 0;
    bit            m_prev_start = 0;
    logic [DW-1:0] m_pend = '0;
    logic [DW-1:0] m_result = '0;
    logic [DW-1:0] m_dout = '0;
    int            fall_cnt = 0;
    logic          prev_eoc = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // With dither the result may sit one step off the sample, saturating at the rails.
    function automatic bit dout_ok(input logic [DW-1:0] act, input logic [DW-1:0] exp);
`ifdef ADC_RESP_DITHER_EN
        if (exp == '0 && act == '0) return 1'b1;
        return (act == exp) ||
               (exp != '1 && act == exp + DW'(1)) ||
               (exp != '0 && act == exp - DW'(1));
`else
        return act == exp;
`endif
    endfunction

    task automatic check_dout(input string tag, input logic [DW-1:0] exp);
        if (dout_ok(dout, exp)) check(tag, 32'(dout), 32'(dout));
        else                    check(tag, 32'(dout), 32'(exp));
    endtask

    task automatic step();
        int  d;
        bit  rise;
        bit  m_busy;
        bit  m_eoc;
        @(posedge clk);
        if (rst) begin
            m_prev_start = 1'b0;
            active       = 1'b0;
            m_result     = '0;
            m_dout       = '0;
        end else begin
            rise   = start && !m_prev_start;
            m_dout = oe ? m_result : '0;
            if (active && !rise && (cyc - last_rise) == ED + CC) m_result = m_pend;
            if (rise) begin
                last_rise = cyc;
                m_pend    = sample_in;
                active    = 1'b1;
            end
            m_prev_start = start;
        end
        cyc++;
        @(negedge clk);
        d      = cyc - last_rise;
        m_busy = active && d <= ED + CC;
        m_eoc  = !(active && d > ED && d <= ED + CC);
        check("eoc", 32'(eoc), 32'(m_eoc));
        check("busy", 32'(busy), 32'(m_busy));
        check_dout("dout", m_dout);
        if (prev_eoc && !eoc) fall_cnt++;
        prev_eoc = eoc;
    endtask

    task automatic pulse_start(input logic [DW-1:0] value);
        sample_in = value;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        int low_cnt;
        rst = 1'b1; start = 1'b0; oe = 1'b0; sample_in = '0;

        // Reset held 3 cycles, then oe with nothing converted yet
        repeat (3) step();
        check("rst_eoc", 32'(eoc), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; oe = 1'b1;
        step(); step();
        check("rst_dout_oe", 32'(dout), 32'd0);
        oe = 1'b0;

        // Basic conversion: eoc low for exactly CC cycles, then oe reads the result
        pulse_start(8'h5A);
        low_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (!eoc) low_cnt++;
        end
        check("basic_eoc_low_cycles", 32'(low_cnt), 32'(CC));
        oe = 1'b1;
        step(); step();
        check_dout("basic_dout", 8'h5A);
        oe = 1'b0;
        step();
        check("basic_dout_off", 32'(dout), 32'd0);

        // Restart at T+10 replaces the conversion; result is the second sample
        pulse_start(8'h77);
        repeat (9) step();
        pulse_start(8'h33);
        repeat (30) step();
        oe = 1'b1;
        step(); step();
        check_dout("restart_result", 8'h33);
        oe = 1'b0;

        // Stale read: previous result visible until one cycle after the EOC rise
        pulse_start(8'hA5);
        repeat (25) step();
        oe = 1'b1;
        pulse_start(8'h11);
        repeat (20) step();
        check("stale_eoc_up", 32'(eoc), 32'd1);
        check_dout("stale_old", 8'hA5);
        step();
        check_dout("stale_new", 8'h11);
        oe = 1'b0;

        // Held start: exactly one conversion
        fall_cnt  = 0;
        sample_in = 8'h3C;
        start     = 1'b1;
        repeat (40) step();
        start = 1'b0;
        repeat (5) step();
        check("held_one_conv", 32'(fall_cnt), 32'd1);

        // Reset mid-conversion clears everything including the result
        pulse_start(8'hC3);
        repeat (11) step();
        rst = 1'b1;
        step();
        check("midrst_eoc", 32'(eoc), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0; oe = 1'b1;
        step(); step();
        check("midrst_result", 32'(dout), 32'd0);

        // Randomized conversions, biased to the rails for saturation coverage
        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            sample_in = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : DW'($urandom);
            start = 1'b1;
            repeat (int'($urandom_range(1, 3))) begin
                oe = 1'($urandom);
                step();
            end
            start = 1'b0;
            repeat (int'($urandom_range(0, 30))) begin
                oe  = 1'($urandom);
                rst = ($urandom_range(0, 199) == 0);
                step();
            end
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
